wb_slv_mem: RTL and testbench

- Synthesizable Wishbone classic-cycle slave backed by a word-organised on-chip memory.
- Sits directly downstream of the Wishbone master BFM, either on a conmax slave port or wired straight to the master in unit benches.
- Consumes single and multi-word read/write, read-modify-write and write-modify-read sequences.
- Wait states, error responses and retry responses are programmable, so master-side and interconnect handshake paths can be exercised.

---
 rtl/wb_slv_mem.sv | 171 +++++++++++++++++
 tb/tb_wb_slv_mem.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/wb_slv_mem.sv
// Wishbone classic-cycle slave backed by a 2^AW x 32-bit on-chip memory.
// Wait states, out-of-window errors and periodic retries are programmable so that
// master and interconnect handshake paths can be exercised.
//
// Ports:
//   clk   system clock, rising edge
//   rst   synchronous active-low reset
//   adr   byte address (adr[1:0] ignored)
//   din   write data
//   dout  read data (registered)
//   cyc   bus cycle valid
//   stb   strobe
//   sel   byte lane selects
//   we    1 = write, 0 = read
//   ack   normal termination
//   err   error termination (address outside the window)
//   rty   retry termination (every RTY_PERIOD-th response)
//   ws    wait states, sampled when an access is accepted
module wb_slv_mem #(
  parameter int unsigned AW         = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int unsigned RTY_PERIOD = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] adr,
  input  logic [31:0] din,
  output logic [31:0] dout,
  input  logic        cyc,
  input  logic        stb,
  input  logic [3:0]  sel,
  input  logic        we,
  output logic        ack,
  output logic        err,
  output logic        rty,
  input  logic [3:0]  ws
);

  localparam int unsigned Depth = 2 ** AW;
  // Exclusive end of the window in 33 bits so a window at the top of the map cannot wrap.
  localparam logic [32:0] WinEnd = {1'b0, BASE_ADDR} + (33'd4 << AW);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic [31:0] rcnt_q, rcnt_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] din_q, din_d;
  logic [3:0]  sel_q, sel_d;
  logic        we_q, we_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic        rty_q, rty_d;
  logic [31:0] dout_q, dout_d;
  logic        mem_we;

  logic [31:0]   mem [Depth];
  logic          in_range;
  logic          rty_hit;
  logic [AW-1:0] word;

  assign in_range = ({1'b0, adr_q} >= {1'b0, BASE_ADDR}) && ({1'b0, adr_q} < WinEnd);
  assign rty_hit  = (RTY_PERIOD != 0) && (rcnt_q == RTY_PERIOD - 1);
  // The base is aligned to the window size, so the offset's word bits equal the address bits.
  assign word     = adr_q[AW+1:2];

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    rcnt_d  = rcnt_q;
    adr_d   = adr_q;
    din_d   = din_q;
    sel_d   = sel_q;
    we_d    = we_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    rty_d   = 1'b0;
    dout_d  = dout_q;
    mem_we  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cyc && stb) begin
          adr_d   = adr;
          din_d   = din;
          sel_d   = sel;
          we_d    = we;
          wcnt_d  = ws;
          state_d = StWait;
        end
      end
      StWait: begin
        if (!(cyc && stb)) begin
          state_d = StIdle;
        end else if (wcnt_q != 4'd0) begin
          wcnt_d = wcnt_q - 4'd1;
        end else begin
          state_d = StResp;
          if (RTY_PERIOD != 0) begin
            rcnt_d = rty_hit ? 32'd0 : rcnt_q + 32'd1;
          end
          if (!in_range) begin
            err_d  = 1'b1;
            dout_d = 32'd0;
          end else if (rty_hit) begin
            rty_d  = 1'b1;
            dout_d = 32'd0;
          end else begin
            ack_d = 1'b1;
            if (we_q) begin
              mem_we = 1'b1;
            end else begin
              dout_d = mem[word];
            end
          end
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      wcnt_q  <= 4'd0;
      rcnt_q  <= 32'd0;
      adr_q   <= 32'd0;
      din_q   <= 32'd0;
      sel_q   <= 4'd0;
      we_q    <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rty_q   <= 1'b0;
      dout_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      rcnt_q  <= rcnt_d;
      adr_q   <= adr_d;
      din_q   <= din_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rty_q   <= rty_d;
      dout_q  <= dout_d;
    end
  end

  // Memory is not reset; a reset on the commit edge still blocks the write.
  always_ff @(posedge clk) begin
    if (rst && mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (sel_q[i]) begin
          mem[word][8*i +: 8] <= din_q[8*i +: 8];
        end
      end
    end
  end

  assign ack  = ack_q;
  assign err  = err_q;
  assign rty  = rty_q;
  assign dout = dout_q;

endmodule

// File: tb/tb_wb_slv_mem.sv
// Directed bench for wb_slv_mem: one instance without retries, one with RTY_PERIOD=3.
module tb_wb_slv_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] adr, din;
  logic        cyc0, cyc1, stb, we;
  logic [3:0]  sel, ws;
  logic [31:0] dout0, dout1;
  logic        ack0, err0, rty0, ack1, err1, rty1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_slv_mem #(.AW(10), .BASE_ADDR(32'h0), .RTY_PERIOD(0)) u_dut0 (
    .clk(clk), .rst(rst), .adr(adr), .din(din), .dout(dout0), .cyc(cyc0), .stb(stb),
    .sel(sel), .we(we), .ack(ack0), .err(err0), .rty(rty0), .ws(ws)
  );

  wb_slv_mem #(.AW(10), .BASE_ADDR(32'h0), .RTY_PERIOD(3)) u_dut1 (
    .clk(clk), .rst(rst), .adr(adr), .din(din), .dout(dout1), .cyc(cyc1), .stb(stb),
    .sel(sel), .we(we), .ack(ack1), .err(err1), .rty(rty1), .ws(ws)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // One access; rsp = {ack,err,rty} at the first response, lat = edges from sample to rise.
  task automatic bus(input bit alt, input logic [31:0] a, input bit w, input logic [3:0] s,
                     input logic [31:0] d, input logic [3:0] wsv,
                     output logic [2:0] rsp, output logic [31:0] rd, output int lat);
    @(negedge clk);
    adr = a; we = w; sel = s; din = d; ws = wsv; stb = 1'b1;
    if (alt) cyc1 = 1'b1;
    else     cyc0 = 1'b1;
    rsp = 3'b000; rd = 32'd0; lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      rsp = alt ? {ack1, err1, rty1} : {ack0, err0, rty0};
      if (rsp != 3'b000) begin
        lat = k - 1;
        rd  = alt ? dout1 : dout0;
        break;
      end
    end
    cyc0 = 1'b0; cyc1 = 1'b0; stb = 1'b0;
    @(negedge clk);
    check("resp_one_cycle", {29'd0, (alt ? {ack1, err1, rty1} : {ack0, err0, rty0})}, 32'd0);
  endtask

  logic [2:0]  rsp;
  logic [31:0] rd;
  int          lat;
  bit          seen;

  initial begin
    // Reset held with a strobe pending: no response, outputs cleared.
    rst = 1'b0; cyc0 = 1'b1; cyc1 = 1'b0; stb = 1'b1; we = 1'b1; sel = 4'hF;
    adr = 32'h20; din = 32'h1234_5678; ws = 4'd0;
    repeat (2) @(negedge clk);
    check("rst_resp", {29'd0, ack0, err0, rty0}, 32'd0);
    check("rst_dout", dout0, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("rst_release_no_ack", {31'd0, ack0}, 32'd0);
    @(negedge clk);
    check("rst_release_ack", {31'd0, ack0}, 32'd1);
    cyc0 = 1'b0; stb = 1'b0;
    @(negedge clk);
    check("rst_release_ack_drop", {31'd0, ack0}, 32'd0);

    // Basic write/read, zero wait states.
    bus(0, 32'h10, 1, 4'hF, 32'hDEAD_BEEF, 4'd0, rsp, rd, lat);
    check("wr_rsp", {29'd0, rsp}, 32'd4);
    check("wr_lat", lat, 32'd1);
    bus(0, 32'h10, 0, 4'hF, 32'h0, 4'd0, rsp, rd, lat);
    check("rd_rsp", {29'd0, rsp}, 32'd4);
    check("rd_data", rd, 32'hDEAD_BEEF);
    bus(0, 32'h20, 0, 4'h0, 32'h0, 4'd0, rsp, rd, lat);
    check("rd_reset_write", rd, 32'h1234_5678);

    // Byte lanes, then sel=0 write leaves memory untouched.
    bus(0, 32'h10, 1, 4'b0010, 32'h0000_AB00, 4'd0, rsp, rd, lat);
    bus(0, 32'h10, 0, 4'hF, 32'h0, 4'd0, rsp, rd, lat);
    check("lane_data", rd, 32'hDEAD_ABEF);
    bus(0, 32'h10, 1, 4'h0, 32'hFFFF_FFFF, 4'd0, rsp, rd, lat);
    check("sel0_rsp", {29'd0, rsp}, 32'd4);
    bus(0, 32'h10, 0, 4'hF, 32'h0, 4'd0, rsp, rd, lat);
    check("sel0_data", rd, 32'hDEAD_ABEF);

    // Wait states.
    bus(0, 32'h10, 0, 4'hF, 32'h0, 4'd3, rsp, rd, lat);
    check("ws3_lat", lat, 32'd4);
    check("ws3_data", rd, 32'hDEAD_ABEF);

    // Abort: strobe dropped during wait states.
    @(negedge clk);
    adr = 32'h10; we = 1'b1; sel = 4'hF; din = 32'h1111_1111; ws = 4'd3;
    cyc0 = 1'b1; stb = 1'b1;
    repeat (2) @(negedge clk);
    cyc0 = 1'b0; stb = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen |= ack0 | err0 | rty0;
    end
    check("abort_no_resp", {31'd0, seen}, 32'd0);
    bus(0, 32'h10, 0, 4'hF, 32'h0, 4'd0, rsp, rd, lat);
    check("abort_no_write", rd, 32'hDEAD_ABEF);

    // Out of window: error, no write, dout cleared.
    bus(0, 32'h0, 1, 4'hF, 32'hCAFE_F00D, 4'd0, rsp, rd, lat);
    bus(0, 32'hFFC, 1, 4'hF, 32'h0BAD_CAFE, 4'd0, rsp, rd, lat);
    check("top_word_rsp", {29'd0, rsp}, 32'd4);
    bus(0, 32'h1000, 1, 4'hF, 32'h5555_5555, 4'd0, rsp, rd, lat);
    check("oor_rsp", {29'd0, rsp}, 32'd2);
    check("oor_dout", rd, 32'd0);
    bus(0, 32'h0, 0, 4'hF, 32'h0, 4'd0, rsp, rd, lat);
    check("oor_no_write", rd, 32'hCAFE_F00D);
    bus(0, 32'hFFC, 0, 4'hF, 32'h0, 4'd0, rsp, rd, lat);
    check("top_word_data", rd, 32'h0BAD_CAFE);

    // Retry every third response.
    for (int i = 0; i < 6; i++) begin
      bus(1, 32'h10, 0, 4'hF, 32'h0, 4'd0, rsp, rd, lat);
      check($sformatf("rty_seq%0d", i), {29'd0, rsp}, ((i % 3) == 2) ? 32'd1 : 32'd4);
      if ((i % 3) == 2) check($sformatf("rty_dout%0d", i), rd, 32'd0);
    end
    bus(1, 32'h10, 0, 4'hF, 32'h0, 4'd0, rsp, rd, lat);
    check("rty_mix0", {29'd0, rsp}, 32'd4);
    bus(1, 32'h1000, 0, 4'hF, 32'h0, 4'd0, rsp, rd, lat);
    check("rty_mix1", {29'd0, rsp}, 32'd2);
    bus(1, 32'h10, 0, 4'hF, 32'h0, 4'd0, rsp, rd, lat);
    check("rty_mix2", {29'd0, rsp}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
